// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file writeback path.
// No logic; widths, register count and the writeback FSM state type.
// Imported by the arbiter top and any other register file clients.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {ST_INIT, ST_RUN} wb_state_t;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant generator: first request at or after ptr_in, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none internally; the caller masks req_in to withhold grants.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_in,
  input  logic [IDX_W-1:0] ptr_in,
  output logic [N-1:0]     gnt_out,
  output logic [IDX_W-1:0] gnt_idx_out,
  output logic             gnt_vld_out
);

  // Search upward from the pointer, modulo N, and grant the first requester found.
  always_comb begin
    int idx;
    idx         = 0;
    gnt_out     = '0;
    gnt_idx_out = '0;
    gnt_vld_out = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_in) + k) % N;
      if (!gnt_vld_out && req_in[idx]) begin
        gnt_vld_out  = 1'b1;
        gnt_out[idx] = 1'b1;
        gnt_idx_out  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback requesters (round-robin),
// after zeroing every register. Latency: one cycle from handshake to we/wa/wd at the port.
// Backpressure: ready is withheld during init and on an init_in cycle. Optional: REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      init_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]         rs1_in,
  input  logic [ADDR_W-1:0]         rs2_in,
  input  logic [DATA_W-1:0]         rd1_in,
  input  logic [DATA_W-1:0]         rd2_in,
  output logic [DATA_W-1:0]         rd1_out,
  output logic [DATA_W-1:0]         rd2_out,
`endif
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic                      we_out,
  output logic [ADDR_W-1:0]         wa_out,
  output logic [DATA_W-1:0]         wd_out,
  output logic                      init_done_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wb_state_t        state_q, state_d;
  reg_addr_t        cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             we_q, we_d;
  reg_addr_t        wa_q, wa_d;
  reg_data_t        wd_q, wd_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  reg_addr_t          sel_addr;
  reg_data_t          sel_data;

  // Requests only reach the arbiter in RUN and not on an init_in cycle, so ready is all zero otherwise.
  assign arb_req = (state_q == ST_RUN && !init_in) ? req_valid_in : '0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_in      (arb_req),
    .ptr_in      (ptr_q),
    .gnt_out     (gnt),
    .gnt_idx_out (gnt_idx),
    .gnt_vld_out (gnt_vld)
  );

  assign sel_addr = req_addr_in[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data = req_data_in[int'(gnt_idx)*DATA_W +: DATA_W];

  // Next-state: init walk writes zeros; RUN registers the granted write and advances the pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    case (state_q)
      ST_INIT: begin
        if (init_in) begin
          // Restart the walk; the next cycle writes address 0 again.
          cnt_d = '0;
        end else begin
          we_d  = 1'b1;
          wa_d  = cnt_q;
          wd_d  = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == reg_addr_t'(NUM_REGS - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      ST_RUN: begin
        if (init_in) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (gnt_vld) begin
          ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          // x0 is hardwired zero: consume the request but never write it.
          if (sel_addr != '0) begin
            we_d = 1'b1;
            wa_d = sel_addr;
            wd_d = sel_data;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State and registered write-port outputs; reset drops any partial write immediately.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign req_ready_out = gnt;
  assign we_out        = we_q;
  assign wa_out        = wa_q;
  assign wd_out        = wd_q;
  assign init_done_out = (state_q == ST_RUN);

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write currently at the port to same-cycle readers; x0 always reads raw.
  assign rd1_out = (we_q && wa_q == rs1_in && rs1_in != '0) ? wd_q : rd1_in;
  assign rd2_out = (we_q && wa_q == rs2_in && rs2_in != '0) ? wd_q : rd2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued by the stimulus,
// a monitor pops and compares on every we_out, and directed checks cover ready/init_done.
// Bypass checks are compiled only with REGFILE_WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk_in;
  logic            rst_n_in;
  logic            init_in;
  logic [NR-1:0]   req_valid_in;
  logic [NR*AW-1:0] req_addr_in;
  logic [NR*DW-1:0] req_data_in;
  logic [NR-1:0]   req_ready_out;
  logic            we_out;
  logic [AW-1:0]   wa_out;
  logic [DW-1:0]   wd_out;
  logic            init_done_out;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]   rs1_in, rs2_in;
  logic [DW-1:0]   rd1_in, rd2_in, rd1_out, rd2_out;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .init_in       (init_in),
    .req_valid_in  (req_valid_in),
    .req_addr_in   (req_addr_in),
    .req_data_in   (req_data_in),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_in        (rs1_in),
    .rs2_in        (rs2_in),
    .rd1_in        (rd1_in),
    .rd2_in        (rd2_in),
    .rd1_out       (rd1_out),
    .rd2_out       (rd2_out),
`endif
    .req_ready_out (req_ready_out),
    .we_out        (we_out),
    .wa_out        (wa_out),
    .wd_out        (wd_out),
    .init_done_out (init_done_out)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid_in[i]          = v;
    req_addr_in[i*AW +: AW]  = a;
    req_data_in[i*DW +: DW]  = d;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_init(input int n);
    for (int i = 0; i < n; i++) push_wr(AW'(i), '0);
  endtask

  task automatic set_abc();
    set_req(0, 1'b1, 5'd5, 32'hA);
    set_req(1, 1'b1, 5'd6, 32'hB);
    set_req(2, 1'b1, 5'd7, 32'hC);
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(posedge clk_in) begin
    #2;
    if (rst_n_in && we_out) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got wa=%0d wd=%0h, expected no write", wa_out, wd_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (wa_out !== mon_e.a || wd_out !== mon_e.d) begin
          n_bad++;
          $display("FAIL write_port: got wa=%0d wd=%0h, expected wa=%0d wd=%0h",
                   wa_out, wd_out, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    rst_n_in     = 1'b0;
    init_in      = 1'b0;
    req_valid_in = '0;
    req_addr_in  = '0;
    req_data_in  = '0;
`ifdef REGFILE_WB_BYPASS_EN
    rs1_in = '0; rs2_in = '0; rd1_in = '0; rd2_in = '0;
`endif
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_we", we_out, 0);
    chk("rst_wa", wa_out, 0);
    chk("rst_wd", wd_out, 0);
    chk("rst_done", init_done_out, 0);
    chk("rst_ready", req_ready_out, 0);

    // Init walk after reset release.
    push_init(32);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk_in);
      #3;
      chk("init_ready", req_ready_out, 0);
      chk("init_done", init_done_out, (i == 31) ? 1 : 0);
    end
    @(posedge clk_in);
    #3;
    chk("init_we_stops", we_out, 0);

    // Round robin with all three requesters valid.
    @(negedge clk_in);
    set_abc();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk_in);
      #1;
      chk("rr_grant", req_ready_out, 3'b001 << (k % 3));
      case (k % 3)
        0: push_wr(5'd5, 32'hA);
        1: push_wr(5'd6, 32'hB);
        default: push_wr(5'd7, 32'hC);
      endcase
    end

    // Requester 1 writes x0: consumed, no write, pointer to 2.
    @(negedge clk_in);
    req_valid_in = '0;
    set_req(1, 1'b1, 5'd0, 32'hDEAD);
    #1;
    chk("x0_grant", req_ready_out, 3'b010);
    @(negedge clk_in);
    chk("x0_no_we", we_out, 0);
    set_abc();
    #1;
    chk("x0_ptr_grant", req_ready_out, 3'b100);
    push_wr(5'd7, 32'hC);

    // init_in pulse while requester 0 is valid.
    @(negedge clk_in);
    req_valid_in = '0;
    set_req(0, 1'b1, 5'd12, 32'h55);
    init_in = 1'b1;
    #1;
    chk("init_pulse_ready", req_ready_out, 0);
    push_init(32);
    @(negedge clk_in);
    init_in = 1'b0;
    chk("reinit_done_low", init_done_out, 0);
    chk("reinit_we_low", we_out, 0);
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("reinit_ready", req_ready_out, 0);
      @(negedge clk_in);
    end
    #1;
    chk("reinit_done", init_done_out, 1);
    chk("held_req_grant", req_ready_out, 3'b001);
    push_wr(5'd12, 32'h55);

    // Reset asserted mid-init with counter at 10.
    @(negedge clk_in);
    req_valid_in = '0;
    init_in = 1'b1;
    push_init(10);
    @(negedge clk_in);
    init_in = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("mid_init_wa", wa_out, 9);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_we", we_out, 0);
    chk("midrst_wa", wa_out, 0);
    chk("midrst_wd", wd_out, 0);
    chk("midrst_done", init_done_out, 0);
    push_init(32);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (32) @(posedge clk_in);
    #3;
    chk("midrst_done_again", init_done_out, 1);

`ifdef REGFILE_WB_BYPASS_EN
    @(negedge clk_in);
    set_req(0, 1'b1, 5'd9, 32'h1234);
    push_wr(5'd9, 32'h1234);
    @(negedge clk_in);
    req_valid_in = '0;
    rs1_in = 5'd9; rd1_in = 32'h0;
    rs2_in = 5'd9; rd2_in = 32'h5;
    #1;
    chk("byp_rd1", rd1_out, 32'h1234);
    chk("byp_rd2", rd2_out, 32'h1234);
    rs1_in = 5'd0; rd1_in = 32'h77;
    rs2_in = 5'd8;
    #1;
    chk("byp_rd1_x0", rd1_out, 32'h77);
    chk("byp_rd2_miss", rd2_out, 32'h5);
`endif

    repeat (3) @(negedge clk_in);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the register file's single write port (write enable, write address, write data) and shares it among NUM_REQ writeback requesters, e.g. ALU, load unit and multiplier.
- After reset, or on request, runs an init sequence that writes zero to every register. Requesters are stalled until it completes.
- Arbitrates between requesters round-robin with a valid/ready handshake.
- Sits between the execute/writeback stages and the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers walked by the init sequence.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- init_in  input  1  one-cycle pulse; restarts the zeroing sequence.
- req_valid_in  input  NUM_REQ  per-requester write request.
- req_addr_in  input  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data_in  input  NUM_REQ*DATA_W  packed write data, same packing.
- req_ready_out  output  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- we_out  output  1  register file write enable.
- wa_out  output  ADDR_W  register file write address.
- wd_out  output  DATA_W  register file write data.
- init_done_out  output  1  high while in RUN.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - we_out=0, wa_out=0, wd_out=0, init_done_out=0, req_ready_out=0.
  - State=INIT, init counter=0, round-robin pointer=0.
- State INIT:
  - req_ready_out is all zero.
  - Each cycle registers we_out=1, wa_out=counter, wd_out=0, then increments the counter.
  - After the write with counter=NUM_REGS-1, go to RUN.
  - Writes therefore appear on cycles 1..NUM_REGS after reset release.
  - init_done_out rises on the same edge that registers the last init write's outputs.
- State RUN:
  - Grant is combinational: the first valid requester at or after the pointer, searching upward modulo NUM_REQ.
  - req_ready_out is the one-hot of that requester; all zero if none is valid.
  - Requesters must not make valid depend on ready.
- Accepted transfer:
  - On the next edge, register we_out=1, wa_out=addr, wd_out=data.
  - Latency is one cycle from handshake to the write being presented at the port.
  - With no transfer, we_out=0; wa_out and wd_out hold their previous values.
- Write to x0 (addr==0): the handshake completes (ready high, request consumed), but we_out=0 is registered.
- Pointer update:
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - The pointer is unchanged when there is no grant, including during INIT.
- Throughput: one write per cycle. A requester holding valid waits at most NUM_REQ-1 grants.
- init_in in RUN:
  - No grant in that cycle; ready is forced to zero combinationally.
  - Next state is INIT with counter=0; init_done_out falls on the next edge.
- init_in in INIT: the counter restarts at 0.
- Reset mid-INIT or mid-RUN: immediate return to reset values; no partial write is presented.
- Request held across INIT: stays pending and is granted normally once in RUN.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- When defined, adds these ports:
  - rs1_in, rs2_in: input, ADDR_W each.
  - rd1_in, rd2_in: input, DATA_W each; raw register file read data.
  - rd1_out, rd2_out: output, DATA_W each.
- Bypass rule for rdN_out:
  - If we_out==1 and wa_out==rsN_in and rsN_in!=0, rdN_out=wd_out.
  - Otherwise rdN_out=rdN_in.
  - Purely combinational; forwards the write in flight at the port.
- When undefined, none of these ports or logic exist.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W and ADDR_W localparams.
  - NUM_REGS.
  - typedef enum logic {ST_INIT, ST_RUN} wb_state_t.
  - typedef logic [ADDR_W-1:0] reg_addr_t.
- Sub-module rr_arbiter: a parameterised round-robin one-hot grant generator.
  - Inputs: request vector and pointer.
  - Outputs: grant vector and grant index.
  - Reused later for memory-port sharing.

Test Plan:
- Reset release -> we_out=1 for exactly 32 consecutive cycles with wa_out=0..31 and wd_out=0; init_done_out=1 after the 32nd; ready stays 0 throughout.
- RUN, all 3 valid continuously with addrs 5/6/7 and data 0xA/0xB/0xC -> grants cycle 0,1,2,0…; we_out presents (5,0xA),(6,0xB),(7,0xC) one cycle after each handshake.
- Requester 1 writes addr 0, data 0xDEAD -> ready_out=3'b010 that cycle; we_out=0 next cycle; pointer moves to 2.
- init_in pulsed while requester 0 is valid -> no grant that cycle; 32 init writes follow; requester 0 is granted in the first RUN cycle.
- rst_n_in asserted mid-INIT at counter=10 -> outputs zero immediately; on release, init restarts at wa_out=0.
- With REGFILE_WB_BYPASS_EN: we_out=1, wa_out=9, wd_out=0x1234, rs1_in=9, rd1_in=0 -> rd1_out=0x1234; with rs1_in=0 -> rd1_out=rd1_in.
